// File: rtl/dlart_xmit_fifo_if.sv
// Transmit-FIFO bus bundle: DCJ11 XBUF push side, Apple II A2XBUF drain side, and the status
// outputs. The master modport belongs to the system driving the FIFO; the FIFO takes the slave.
interface dlart_xmit_fifo_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) ();

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wr_stb;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req;
  logic [WIDTH-1:0] rd_data;
  logic             rd_avail;
  logic             xdone;
  logic [LW-1:0]    level;
  logic             ovf;

  modport master (
    output flush,
    output wr_stb,
    output wr_data,
    output rd_req,
    input  rd_data,
    input  rd_avail,
    input  xdone,
    input  level,
    input  ovf
  );

  modport slave (
    input  flush,
    input  wr_stb,
    input  wr_data,
    input  rd_req,
    output rd_data,
    output rd_avail,
    output xdone,
    output level,
    output ovf
  );

endinterface

// File: rtl/dlart_xmit_fifo.sv
// DLART console transmit FIFO, edge-triggered push (XBUF write) and pop (A2XBUF read).
// Define DLART_XMIT_FIFO_SYNC_EN to pass rd_req through a 2-flop synchronizer first.
module dlart_xmit_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input logic               clk_x3,
  input logic               rstb,
  dlart_xmit_fifo_if.slave  io_xmit
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FullLvl = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_ovf;
  logic             r_avail;
  logic             r_xdone;
  logic             r_wr_hist;
  logic             r_rd_hist;

  logic [PW-1:0]    w_wr_ptr_d;
  logic [PW-1:0]    w_rd_ptr_d;
  logic [LW-1:0]    w_level_d;
  logic             w_ovf_d;
  logic             w_avail_d;
  logic             w_xdone_d;
  logic             w_mem_we;
  logic             w_rd_in;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

`ifdef DLART_XMIT_FIFO_SYNC_EN
  // Reset high so a request already asserted at reset release is not seen as a rise.
  logic [1:0] r_rd_sync;

  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      r_rd_sync <= 2'b11;
    end else begin
      r_rd_sync <= {r_rd_sync[0], io_xmit.rd_req};
    end
  end

  assign w_rd_in = r_rd_sync[1];
`else
  assign w_rd_in = io_xmit.rd_req;
`endif

  always_comb begin
    w_push     = io_xmit.wr_stb & ~r_wr_hist;
    w_pop      = w_rd_in & ~r_rd_hist;
    w_full     = (r_level == FullLvl);
    w_empty    = (r_level == '0);
    w_do_push  = w_push & ~w_full;
    w_do_pop   = w_pop & ~w_empty;

    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_level_d  = r_level;
    w_ovf_d    = r_ovf;
    w_avail_d  = r_avail;
    w_xdone_d  = r_xdone;
    w_mem_we   = 1'b0;

    if (io_xmit.flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_level_d  = '0;
      w_ovf_d    = 1'b0;
      w_avail_d  = 1'b0;
      w_xdone_d  = 1'b1;
    end else begin
      w_mem_we = w_do_push;
      if (w_do_push) begin
        w_wr_ptr_d = r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        w_rd_ptr_d = r_rd_ptr + PW'(1);
      end
      // At full, a simultaneous pop still completes but the push is dropped.
      w_level_d = r_level + LW'(w_do_push) - LW'(w_do_pop);
      w_ovf_d   = r_ovf | (w_push & w_full);
      w_avail_d = (w_level_d != '0);
      w_xdone_d = (w_level_d != FullLvl);
    end
  end

  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_avail   <= 1'b0;
      r_xdone   <= 1'b1;
      r_wr_hist <= 1'b1;
      r_rd_hist <= 1'b1;
    end else begin
      r_wr_ptr  <= w_wr_ptr_d;
      r_rd_ptr  <= w_rd_ptr_d;
      r_level   <= w_level_d;
      r_ovf     <= w_ovf_d;
      r_avail   <= w_avail_d;
      r_xdone   <= w_xdone_d;
      // History tracks inputs through flush too, so a held strobe cannot push afterwards.
      r_wr_hist <= io_xmit.wr_stb;
      r_rd_hist <= w_rd_in;
    end
  end

  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[r_wr_ptr] <= io_xmit.wr_data;
    end
  end

  assign io_xmit.rd_data  = r_mem[r_rd_ptr];
  assign io_xmit.rd_avail = r_avail;
  assign io_xmit.xdone    = r_xdone;
  assign io_xmit.level    = r_level;
  assign io_xmit.ovf      = r_ovf;

endmodule
